// File: rtl/day1_safe.sv
// Circular 0..99 dial accumulator counting landings on 0; DAY1_CLICK_COUNT_EN also counts passes through 0.
// One instruction per cycle when valid, pos/result registered with 1-cycle latency, no back-pressure.
module day1_safe #(
  parameter int unsigned START_POS = 50,
  parameter int unsigned DIAL_SIZE = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        dir,
  input  logic [15:0] amt,
  output logic [6:0]  pos,
  output logic [31:0] result
);

  localparam logic [7:0]  LP_DIAL   = 8'(DIAL_SIZE);
  localparam logic [15:0] LP_DIAL16 = 16'(DIAL_SIZE);
  localparam logic [6:0]  LP_START  = 7'(START_POS);

  logic [6:0]  r_pos;
  logic [31:0] r_result;

  logic [6:0]  w_step;
  logic [7:0]  w_sum;
  logic [6:0]  w_pos_next;
  logic [31:0] w_incr;
`ifdef DAY1_CLICK_COUNT_EN
  logic [15:0] w_quot;
  logic        w_edge;
`endif

  always_comb begin
    w_step = 7'(amt % LP_DIAL16);
    // Left rotation is done as adding the complement so both directions share one wrap stage.
    if (dir) begin
      w_sum = {1'b0, r_pos} + {1'b0, w_step};
    end else begin
      w_sum = {1'b0, r_pos} + LP_DIAL - {1'b0, w_step};
    end
    if (w_sum >= LP_DIAL) begin
      w_pos_next = 7'(w_sum - LP_DIAL);
    end else begin
      w_pos_next = w_sum[6:0];
    end
  end

`ifdef DAY1_CLICK_COUNT_EN
  always_comb begin
    w_quot = amt / LP_DIAL16;
    w_edge = 1'b0;
    if (w_step != 7'd0) begin
      if (dir) begin
        w_edge = (w_sum >= LP_DIAL);
      end else begin
        // Starting on 0 and moving left does not pass 0 again within the partial turn.
        w_edge = (r_pos != 7'd0) && (w_step >= r_pos);
      end
    end
    w_incr = 32'(w_quot) + 32'(w_edge);
  end
`else
  always_comb begin
    w_incr = (w_pos_next == 7'd0) ? 32'd1 : 32'd0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos    <= LP_START;
      r_result <= 32'd0;
    end else if (valid) begin
      r_pos    <= w_pos_next;
      r_result <= r_result + w_incr;
    end
  end

  assign pos    = r_pos;
  assign result = r_result;

endmodule

// File: tb/tb_day1_safe.sv
// Directed vector bench for day1_safe; expected values hand-computed for both DAY1_CLICK_COUNT_EN settings.
module tb_day1_safe;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        dir;
  logic [15:0] amt;
  logic [6:0]  pos;
  logic [31:0] result;

  int total;
  int bad;

`ifdef DAY1_CLICK_COUNT_EN
  localparam bit CLICK = 1'b1;
`else
  localparam bit CLICK = 1'b0;
`endif

  typedef struct {
    bit          do_rst;
    bit          d;
    int unsigned a;
    int unsigned exp_pos;
    int unsigned exp_res;
    int unsigned exp_res_click;
  } vec_t;

  vec_t vecs[15];

  day1_safe #(.START_POS(50), .DIAL_SIZE(100)) dut (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid),
    .dir    (dir),
    .amt    (amt),
    .pos    (pos),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input bit rs, input bit d, input int unsigned a,
                         input int unsigned p, input int unsigned r, input int unsigned rc);
    vecs[i].do_rst        = rs;
    vecs[i].d             = d;
    vecs[i].a             = a;
    vecs[i].exp_pos       = p;
    vecs[i].exp_res       = r;
    vecs[i].exp_res_click = rc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input bit d, input int unsigned a);
    @(negedge clk);
    valid = 1'b1;
    dir   = d;
    amt   = 16'(a);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  initial begin
    logic [6:0]  hold_pos;
    logic [31:0] hold_res;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    valid = 1'b0;
    dir   = 1'b0;
    amt   = 16'd0;

    // Sequence from reset, one instruction every 2 cycles
    set_vec(0,  1, 0, 68,    82, 0, 1);
    set_vec(1,  0, 0, 30,    52, 0, 1);
    set_vec(2,  0, 1, 48,    0,  1, 2);
    set_vec(3,  0, 0, 5,     95, 1, 2);
    set_vec(4,  0, 1, 60,    55, 1, 3);
    set_vec(5,  0, 0, 55,    0,  2, 4);
    set_vec(6,  0, 0, 1,     99, 2, 4);
    set_vec(7,  0, 0, 99,    0,  3, 5);
    set_vec(8,  0, 1, 14,    14, 3, 5);
    set_vec(9,  0, 0, 82,    32, 3, 6);
    // Wrap through 0 in both directions
    set_vec(10, 1, 1, 50,    0,  1, 1);
    set_vec(11, 0, 0, 1,     99, 1, 1);
    set_vec(12, 0, 1, 1,     0,  2, 2);
    // Large amounts
    set_vec(13, 1, 1, 1000,  50, 0, 10);
    set_vec(14, 0, 0, 65535, 15, 0, 665);

    // Asynchronous reset asserted mid-cycle, valid ignored while held
    @(negedge clk);
    #2;
    rst   = 1'b1;
    #1;
    check("reset_async_pos", 32'(pos), 32'd50);
    check("reset_async_res", result, 32'd0);
    valid = 1'b1;
    dir   = 1'b1;
    amt   = 16'd7;
    @(posedge clk);
    #1;
    check("reset_hold_pos", 32'(pos), 32'd50);
    check("reset_hold_res", result, 32'd0);
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_idle_pos", 32'(pos), 32'd50);
    check("post_reset_idle_res", result, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_rst) do_reset();
      send(vecs[i].d, vecs[i].a);
      check($sformatf("vec%0d_pos", i), 32'(pos), 32'(vecs[i].exp_pos));
      check($sformatf("vec%0d_res", i), result,
            CLICK ? 32'(vecs[i].exp_res_click) : 32'(vecs[i].exp_res));
      @(negedge clk);
    end

    // Back-to-back: valid high for three consecutive edges
    do_reset();
    @(negedge clk);
    valid = 1'b1; dir = 1'b0; amt = 16'd50;
    @(posedge clk); #1;
    check("b2b_0_pos", 32'(pos), 32'd0);
    @(negedge clk);
    dir = 1'b1; amt = 16'd0;
    @(posedge clk); #1;
    check("b2b_1_pos", 32'(pos), 32'd0);
    @(negedge clk);
    dir = 1'b0; amt = 16'd100;
    @(posedge clk); #1;
    check("b2b_2_pos", 32'(pos), 32'd0);
    @(negedge clk);
    valid = 1'b0;
    check("b2b_res", result, CLICK ? 32'd2 : 32'd3);

    // Idle: random dir/amt with valid low
    hold_pos = pos;
    hold_res = result;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      dir = 1'($urandom_range(0, 1));
      amt = 16'($urandom_range(0, 65535));
    end
    @(posedge clk); #1;
    check("idle_pos", 32'(pos), 32'(hold_pos));
    check("idle_res", result, hold_res);
    check("idle_pos_abs", 32'(pos), 32'd0);

    // Reset mid-stream discards accumulated count
    send(1'b1, 32'd3);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midstream_rst_pos", 32'(pos), 32'd50);
    check("midstream_rst_res", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
